// File: rtl/serial_alu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : serial_alu_sequencer
//  Brief    : Bit-serial ALU front end; one 1-bit slice walked across WIDTH bits
//             with start/busy/done handshake, SLT resolution and zero/ovf flags.
//  Revision : 1.0 - initial release
// ============================================================================
module serial_alu_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic [3:0]       alu_ctrl,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow
);

    localparam int                 c_IDX_W = $clog2(WIDTH);
    localparam logic [c_IDX_W-1:0] c_LAST  = c_IDX_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [3:0]         r_ctrl;
    logic [c_IDX_W-1:0] r_idx;
    logic               r_carry;
    logic [WIDTH-1:0]   r_shadow;
    logic               r_ovf;
    logic               r_set;
    logic [WIDTH-1:0]   r_result;
    logic               r_zero;
    logic               r_overflow;
    logic               r_done;

    logic             w_ai;
    logic             w_bi;
    logic             w_sum;
    logic             w_cout;
    logic             w_bit;
    logic             w_last;
    logic             w_ovf_msb;
    logic             w_legal;
    logic [WIDTH-1:0] w_final;

    // Single 1-bit slice evaluated at the current bit position
    assign w_ai      = r_a[r_idx] ^ r_ctrl[3];
    assign w_bi      = r_b[r_idx] ^ r_ctrl[2];
    assign w_sum     = w_ai ^ w_bi ^ r_carry;
    assign w_cout    = (w_ai & w_bi) | (w_ai & r_carry) | (w_bi & r_carry);
    assign w_ovf_msb = r_carry ^ w_cout;
    assign w_last    = (r_idx == c_LAST);

    always_comb begin
        w_bit = 1'b0;
        case (r_ctrl[1:0])
            2'b00:   w_bit = w_ai & w_bi;
            2'b01:   w_bit = w_ai | w_bi;
            2'b10:   w_bit = w_sum;
            default: w_bit = 1'b0;
        endcase
    end

    always_comb begin
        w_legal = 1'b0;
        case (r_ctrl)
            4'b0000, 4'b0001, 4'b0010,
            4'b0110, 4'b0111, 4'b1100: w_legal = 1'b1;
            default:                   w_legal = 1'b0;
        endcase
    end

    // SLT reports the MSB set signal on bit 0; unsupported codes collapse to 0
    always_comb begin
        w_final = r_shadow;
        if (r_ctrl[1:0] == 2'b11) begin
            w_final[0] = r_set;
        end
        if (!w_legal) begin
            w_final = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next_state = S_RUN;
            S_RUN:    if (w_last) w_next_state = S_FINISH;
            S_FINISH: w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a        <= '0;
            r_b        <= '0;
            r_ctrl     <= '0;
            r_idx      <= '0;
            r_carry    <= 1'b0;
            r_shadow   <= '0;
            r_ovf      <= 1'b0;
            r_set      <= 1'b0;
            r_result   <= '0;
            r_zero     <= 1'b0;
            r_overflow <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a     <= src_a;
                        r_b     <= src_b;
                        r_ctrl  <= alu_ctrl;
                        r_idx   <= '0;
                        r_carry <= alu_ctrl[2];
                    end
                end
                S_RUN: begin
                    r_shadow[r_idx] <= w_bit;
                    r_carry         <= w_cout;
                    if (w_last) begin
                        r_ovf <= w_ovf_msb;
                        r_set <= w_sum ^ w_ovf_msb;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                S_FINISH: begin
                    r_result   <= w_final;
                    r_zero     <= (w_final == '0);
                    r_overflow <= (w_legal && (r_ctrl[1:0] == 2'b10)) ? r_ovf : 1'b0;
                    r_done     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy     = (r_state != S_IDLE);
    assign done     = r_done;
    assign result   = r_result;
    assign zero     = r_zero;
    assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_serial_alu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_alu_sequencer
//  Brief    : Scoreboard bench for serial_alu_sequencer (WIDTH = 32).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_serial_alu_sequencer;

    localparam int WIDTH = 32;

    logic             clk      = 1'b0;
    logic             rst_n    = 1'b0;
    logic             start    = 1'b0;
    logic [WIDTH-1:0] src_a    = '0;
    logic [WIDTH-1:0] src_b    = '0;
    logic [3:0]       alu_ctrl = '0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             overflow;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        string            name;
        logic [WIDTH-1:0] res;
        logic             z;
        logic             o;
        int               done_cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    serial_alu_sequencer #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .src_a    (src_a),
        .src_b    (src_b),
        .alu_ctrl (alu_ctrl),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .zero     (zero),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input string name, input logic [WIDTH-1:0] a,
                                   input logic [WIDTH-1:0] b, input logic [3:0] c, input int dc);
        exp_t e;
        logic [WIDTH-1:0] r;
        logic o;
        r = '0;
        o = 1'b0;
        case (c)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0010: begin
                r = a + b;
                o = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
            end
            4'b0110: begin
                r = a - b;
                o = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
            end
            4'b0111: r = ($signed(a) < $signed(b)) ? WIDTH'(1) : '0;
            4'b1100: r = ~(a | b);
            default: r = '0;
        endcase
        e.name     = name;
        e.res      = r;
        e.z        = (r == '0);
        e.o        = o;
        e.done_cyc = dc;
        return e;
    endfunction

    // Call between edges while the DUT is idle; start is sampled at the next edge
    task automatic issue(input string name, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic [3:0] c);
        src_a    = a;
        src_b    = b;
        alu_ctrl = c;
        start    = 1'b1;
        sb.push_back(model(name, a, b, c, cyc + WIDTH + 2));
        @(posedge clk);
        #1;
        start    = 1'b0;
        src_a    = $urandom;
        src_b    = $urandom;
        alu_ctrl = 4'($urandom);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done !== 1'b1 && n < WIDTH * 3);
        if (done !== 1'b1) check("done_timeout", WIDTH'(done), WIDTH'(1));
    endtask

    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                check("spurious_done", WIDTH'(done), '0);
            end else begin
                mon_e = sb.pop_front();
                check({mon_e.name, "_result"},   result,           mon_e.res);
                check({mon_e.name, "_zero"},     WIDTH'(zero),     WIDTH'(mon_e.z));
                check({mon_e.name, "_overflow"}, WIDTH'(overflow), WIDTH'(mon_e.o));
                check({mon_e.name, "_latency"},  WIDTH'(cyc),      WIDTH'(mon_e.done_cyc));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic seen;

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy",     WIDTH'(busy),     '0);
        check("rst_done",     WIDTH'(done),     '0);
        check("rst_result",   result,           '0);
        check("rst_zero",     WIDTH'(zero),     '0);
        check("rst_overflow", WIDTH'(overflow), '0);
        rst_n = 1'b1;
        @(negedge clk);

        issue("add_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 4'b0010);
        wait_done();
        @(negedge clk);
        check("done_one_cycle", WIDTH'(done), '0);
        check("result_hold",    result,       32'h8000_0000);

        issue("sub_zero",  32'h0000_0005, 32'h0000_0005, 4'b0110); wait_done();
        issue("slt_neg",   32'hFFFF_FFFF, 32'h0000_0001, 4'b0111); wait_done();
        issue("slt_ovf",   32'h8000_0000, 32'h0000_0001, 4'b0111); wait_done();
        issue("slt_false", 32'h0000_0001, 32'hFFFF_FFFF, 4'b0111); wait_done();
        issue("nor",       32'h0000_0000, 32'h0000_FFFF, 4'b1100); wait_done();
        issue("and",       32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'b0000); wait_done();
        issue("or",        32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'b0001); wait_done();

        // Starts during an operation must be ignored
        issue("ignored_start", 32'h1234_5678, 32'h1111_1111, 4'b0010);
        repeat (4) @(negedge clk);
        src_a = 32'hFFFF_FFFF; src_b = 32'hFFFF_FFFF; alu_ctrl = 4'b0001; start = 1'b1;
        check("busy_run", WIDTH'(busy), WIDTH'(1));
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        src_a = 32'h0; src_b = 32'h0; alu_ctrl = 4'b1100; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();

        // Start in the done cycle is accepted; latency check covers the spacing
        issue("b2b_sub", 32'h0000_000A, 32'h0000_0003, 4'b0110);
        wait_done();

        issue("illegal", 32'h0000_FFFF, 32'h0000_0001, 4'b0101); wait_done();
        issue("pre_rst", 32'h7FFF_FFFF, 32'h0000_0001, 4'b0010); wait_done();

        // Abort mid-operation at idx 10
        issue("aborted", 32'h0000_0001, 32'h0000_0002, 4'b0010);
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb.delete();
        check("abort_busy",     WIDTH'(busy),     '0);
        check("abort_done",     WIDTH'(done),     '0);
        check("abort_result",   result,           '0);
        check("abort_zero",     WIDTH'(zero),     '0);
        check("abort_overflow", WIDTH'(overflow), '0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("abort_no_done", WIDTH'(seen), '0);

        issue("add_after_rst", 32'h0000_0003, 32'h0000_0004, 4'b0010);
        wait_done();
        repeat (3) @(negedge clk);
        check("final_queue_empty", WIDTH'(sb.size()), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
